// File: rtl/if_id_fetch_queue.sv
// Fetch-to-decode instruction queue: a small circular buffer of {instr, pc, pc+4}
// triples that presents the oldest entry to decode and holds the PC when full.
module if_id_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                InstrF,
  input  logic [31:0]                PCF,
  input  logic [31:0]                PCPlus4F,
  input  logic                       ValidF,
  output logic                       FetchEnF,
  input  logic                       StallD,
  input  logic                       FlushD,
  output logic [31:0]                InstrD,
  output logic [31:0]                PCD,
  output logic [31:0]                PCPlus4D,
  output logic                       ValidD,
  output logic [$clog2(DEPTH+1)-1:0] QCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [95:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;
  logic [95:0]   head;

  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    push     = ValidF & ~full & ~FlushD;
    pop      = ~empty & ~StallD & ~FlushD;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FlushD) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; the empty check below masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {InstrF, PCF, PCPlus4F};
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    FetchEnF = ~full;
    QCount   = count_q;
    ValidD   = ~empty;
    InstrD   = NOP_INSTR;
    PCD      = '0;
    PCPlus4D = '0;
    if (!empty) begin
      InstrD   = head[95:64];
      PCD      = head[63:32];
      PCPlus4D = head[31:0];
    end
  end

endmodule

// File: doc/if_id_fetch_queue.md
# if_id_fetch_queue

Instruction fetch queue between the fetch stage (PC register plus instruction memory) and the decode stage. It captures each fetched {instruction, PC, PC+4} triple into a small circular buffer. It presents the oldest entry to decode and back-pressures the PC register through its enable when full. It also discards all queued entries on a control-flow redirect.

## Interface
Parameters:
- DEPTH, default 4: number of queue entries; power of two, ≥ 2.
- NOP_INSTR, default 32'h00000013: instruction presented to decode when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- InstrF  input  32  instruction read from instruction memory at PCF.
- PCF  input  32  current fetch PC.
- PCPlus4F  input  32  PCF + 4.
- ValidF  input  1  fetch triple is valid this cycle.
- FetchEnF  output  1  drives the PC register EN: 1 = PC may advance, 0 = hold.
- StallD  input  1  decode cannot consume this cycle.
- FlushD  input  1  redirect; empties the queue.
- InstrD  output  32  head instruction, or NOP_INSTR when empty.
- PCD  output  32  head PC, or 0 when empty.
- PCPlus4D  output  32  head PC+4, or 0 when empty.
- ValidD  output  1  head entry is valid.
- QCount  output  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage is a DEPTH-entry array of 96-bit {InstrF, PCF, PCPlus4F} with write pointer wr_ptr, read pointer rd_ptr and occupancy count. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- full = (count == DEPTH); empty = (count == 0).
- FetchEnF = ~full. It is combinational from count only and has no path from StallD, FlushD or ValidF.
- Push: push = ValidF & ~full & ~FlushD. The triple is written at wr_ptr and wr_ptr increments.
- Pop: pop = ~empty & ~StallD & ~FlushD. rd_ptr increments.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged.
- Push while full is impossible by construction. If ValidF=1 while full, the input is ignored. Fetch holds the same PC because FetchEnF=0, so nothing is lost.
- Flush (highest priority): wr_ptr, rd_ptr and count clear to 0 at the next edge. Any same-cycle push and pop are suppressed.
- Head outputs are read combinationally from array[rd_ptr] when ~empty. When empty, they are forced to NOP_INSTR / 0 / 0 with ValidD=0.
- The storage array is not reset. Only pointers and count are reset, and the empty-forcing hides stale contents.

## Timing
- Reset (reset_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Outputs immediately become QCount=0, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, FetchEnF=1.
- Reset asserted mid-operation discards all entries without waiting for a clock edge. Deassertion takes effect at the next rising edge.
- Latency: a triple pushed at edge N appears on the D outputs (ValidD=1) right after edge N, i.e. in decode's cycle N+1.
- Throughput: one push and one pop per cycle are sustained indefinitely with count constant.
- Full boundary: at count=DEPTH, FetchEnF=0 in the same cycle. A pop at edge N gives count=DEPTH−1 and FetchEnF=1 after edge N. The full-plus-pop cycle therefore costs one fetch bubble; this is accepted.
- Empty boundary: a pop of the last entry and a push in the same cycle leave count=1, with the new entry at head after the edge.
- Flush with StallD=1 or ValidF=1 in the same cycle still yields count=0 after the edge.

## Test plan
- Reset: drive reset_n=0 mid-stream with 3 entries queued → QCount=0, ValidD=0, InstrD=32'h00000013 and FetchEnF=1 before the next clk edge.
- Streaming: ValidF=1 for PCF=0x00,0x04,…,0x1C with StallD=0 → PCD sequence 0x00..0x1C in order, one cycle behind fetch, QCount constant at 1.
- Fill: StallD=1 with 5 valid fetches and DEPTH=4 → QCount reaches 4 and FetchEnF=0 after the 4th edge. The 5th triple is not written, and head stays PCD=0x00.
- Drain and wrap: from full, release StallD for 4 cycles while pushing PCF=0x20.. → pops return 0x00,0x04,0x08,0x0C then 0x20. Pointer wrap is exercised with no duplication or loss.
- Flush: queue holding 3 entries, assert FlushD with ValidF=1 and StallD=0 for one cycle → QCount=0 and ValidD=0 after the edge. The flush-cycle triple is dropped, and the next fetch (PCF=0x100) is head one cycle later.
- Simultaneous: count=1, ValidF=1, StallD=0 → QCount stays 1 and the head advances to the newly pushed PC.
